des_mode_ctrl: RTL
==================

# des_mode_ctrl

Multi-channel block-cipher mode controller between the stream/config side and the existing iterative DES datapath. Each of NUM_CH channels holds its own key, IV/counter and mode. The controller applies ECB, CBC or (optionally) CTR chaining around a single shared DES core port. Blocks are processed one at a time; the IV is updated after each block and the result is returned with a valid/ready handshake.

## Interface
Parameters:
- NUM_CH, 4: number of channel contexts (≥1); channel index width CH_W = max(1,$clog2(NUM_CH)).
- DATA_W, 64: block width; key width equals DATA_W.
- TIMEOUT, 64: cycles to wait for core_valid before aborting with error.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  config write strobe.
- cfg_ready  out  1  config write accepted when high.
- cfg_ch  in  CH_W  target channel.
- cfg_sel  in  2  0 key, 1 IV/counter, 2 control ([1:0] mode, [2] encrypt), 3 ignored.
- cfg_wdata  in  DATA_W  write data.
- in_valid / in_ready  in / out  1  input block handshake.
- in_ch  in  CH_W  channel of input block.
- in_data  in  DATA_W  plaintext/ciphertext block.
- out_valid / out_ready  out / in  1  result handshake.
- out_ch  out  CH_W  channel of result.
- out_data  out  DATA_W  result block.
- out_err  out  1  result is an error (bad mode or timeout).
- core_enable  out  1  one-cycle start pulse to DES core.
- core_encrypt  out  1  1 encrypt, 0 decrypt.
- core_key  out  DATA_W  key to core.
- core_in  out  DATA_W  block to core.
- core_valid  in  1  core result strobe.
- core_out  in  DATA_W  core result.

## Operation
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: in_ready=1. On in_valid, latch in_ch/in_data and go to ISSUE. A reserved mode (3, or 2 without CTR support) goes directly to HOLD with out_err=1 and out_data=0.
  - ISSUE: core_enable=1 for exactly one cycle, then WAIT.
  - WAIT: on core_valid, compute the result, update the IV, then HOLD. If TIMEOUT cycles elapse without core_valid, go to HOLD with out_err=1, out_data=0, and leave the IV unchanged.
  - HOLD: out_valid=1 with data stable until out_ready, then IDLE.
- Mode rules (x = latched input, iv = channel IV):
  - ECB (0): core_in=x; out=core_out; IV untouched.
  - CBC (1), encrypt: core_in=x^iv; out=core_out; iv←core_out.
  - CBC (1), decrypt: core_in=x; out=core_out^iv; iv←x.
  - CTR (2): core_encrypt forced 1; core_in=iv; out=core_out^x; iv←iv+1 mod 2^DATA_W.
- Config writes:
  - A write takes effect on the cycle it is accepted.
  - cfg_ready=0 only when cfg_ch equals the latched channel and state≠IDLE. Writes to other channels proceed concurrently.
  - cfg_sel=3 is accepted and ignored.
  - cfg_ch ≥ NUM_CH is accepted and ignored; in_ch ≥ NUM_CH produces out_err=1.
- Reset values:
  - All contexts: key 0, IV 0, mode ECB, encrypt 1.
  - Outputs: in_ready 1, cfg_ready 1, out_valid 0, out_err 0, out_data 0, out_ch 0, core_enable 0, core_in 0, core_key 0, core_encrypt 1.
- Reset mid-operation aborts the block with no output, clears all contexts, and returns the FSM to IDLE.

## Timing
- Input accepted at edge T. core_enable is high in cycle T+1. core_out is captured on the edge where core_valid=1.
- out_valid rises the cycle after core_valid. With a 1-cycle core, out_valid is high in cycle T+3.
- core_key, core_in and core_encrypt are registered and stay stable from ISSUE until leaving WAIT.
- Throughput: one block per 4 cycles minimum with a 1-cycle core and out_ready held high.
- core_valid outside WAIT is ignored.
- The timeout counter restarts on every ISSUE.

## Configuration
- DES_MODE_CTR_EN defined: CTR mode (2) is supported, including the counter adder.
- DES_MODE_CTR_EN undefined: mode 2 is treated as reserved (error result, no core issue), and no adder is synthesised.

## Structure
- Package des_mode_pkg holds:
  - mode_e (ECB, CBC, CTR, RSV)
  - cfg_sel_e
  - state_e
  - DATA_W default constant
- Sub-module des_ch_ctx: per-channel key/IV/control register file. It provides a write port shared by config and IV update, with the IV update taking priority in the same cycle, and a read port indexed by the latched channel.

## Test plan
- ECB encrypt on ch0: key 133457799BBCDFF1, in 0123456789ABCDEF, bench model core → out 85E813540F0AB405, out_ch 0, out_err 0, out_valid at T+3.
- CBC encrypt on ch1 with IV 0: two blocks 0123456789ABCDEF → first out 85E813540F0AB405; second core_in 84CB563386A179EA.
- CBC decrypt round-trip: the ciphertext from the previous test, fed to ch2 with the same key and IV, returns the original two plaintexts.
- CTR on ch3 with IV FFFFFFFFFFFFFFFF: two blocks → core_in FFFFFFFFFFFFFFFF then 0000000000000000. With DES_MODE_CTR_EN undefined, the block instead returns out_err=1 and no core_enable.
- Timeout: core_valid held at 0 → out_err=1 exactly TIMEOUT cycles after WAIT entry, and the IV is unchanged.
- Backpressure and reset:
  - out_ready low for 10 cycles keeps out_data stable and in_ready 0.
  - cfg write to the busy channel sees cfg_ready 0; a write to another channel sees cfg_ready 1.
  - rst asserted in WAIT clears all outputs immediately.

Source files
------------

// File: rtl/des_mode_pkg.sv
// Shared types and constants for the DES block-cipher mode controller.
// CTR support is selected with the DES_MODE_CTR_EN macro (see des_mode_ctrl).
package des_mode_pkg;

  localparam int DES_DATA_W = 64;

  typedef enum logic [1:0] {
    ECB = 2'd0,
    CBC = 2'd1,
    CTR = 2'd2,
    RSV = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    CFG_KEY  = 2'd0,
    CFG_IV   = 2'd1,
    CFG_CTRL = 2'd2,
    CFG_NOP  = 2'd3
  } cfg_sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/des_ch_ctx.sv
// Per-channel key / IV / control register file for des_mode_ctrl.
// One write port shared by config writes and the post-block IV update
// (IV update wins on a same-cycle collision), one read port.
module des_ch_ctx
  import des_mode_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = DES_DATA_W,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [1:0]        wr_sel_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              upd_en_i,
  input  logic [CH_W-1:0]   upd_ch_i,
  input  logic [DATA_W-1:0] upd_iv_i,
  input  logic [CH_W-1:0]   rd_ch_i,
  output logic [DATA_W-1:0] key_o,
  output logic [DATA_W-1:0] iv_o,
  output mode_e             mode_o,
  output logic              enc_o,
  output logic              ok_o
);

  logic [DATA_W-1:0] key_q [NUM_CH];
  logic [DATA_W-1:0] iv_q  [NUM_CH];
  mode_e             mode_q[NUM_CH];
  logic              enc_q [NUM_CH];

  // Context storage; channel numbers outside 0..NUM_CH-1 match no entry and are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        key_q[i]  <= '0;
        iv_q[i]   <= '0;
        mode_q[i] <= ECB;
        enc_q[i]  <= 1'b1;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en_i && (wr_ch_i == CH_W'(i))) begin
          case (cfg_sel_e'(wr_sel_i))
            CFG_KEY:  key_q[i] <= wr_data_i;
            CFG_IV:   iv_q[i]  <= wr_data_i;
            CFG_CTRL: begin
              mode_q[i] <= mode_e'(wr_data_i[1:0]);
              enc_q[i]  <= wr_data_i[2];
            end
            default: ;
          endcase
        end
        // Placed after the config write so the chaining update takes priority.
        if (upd_en_i && (upd_ch_i == CH_W'(i))) begin
          iv_q[i] <= upd_iv_i;
        end
      end
    end
  end

  // Read mux; ok_o flags that the index names an existing channel.
  always_comb begin
    key_o  = '0;
    iv_o   = '0;
    mode_o = ECB;
    enc_o  = 1'b1;
    ok_o   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch_i == CH_W'(i)) begin
        key_o  = key_q[i];
        iv_o   = iv_q[i];
        mode_o = mode_q[i];
        enc_o  = enc_q[i];
        ok_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/des_mode_ctrl.sv
// Multi-channel ECB/CBC/CTR mode controller in front of a shared iterative
// DES core. Define DES_MODE_CTR_EN to enable CTR mode (and its counter adder);
// without it mode 2 is reserved and returns an error result.
module des_mode_ctrl
  import des_mode_pkg::*;
#(
  parameter int  NUM_CH  = 4,
  parameter int  DATA_W  = DES_DATA_W,
  parameter int  TIMEOUT = 64,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              core_enable,
  output logic              core_encrypt,
  output logic [DATA_W-1:0] core_key,
  output logic [DATA_W-1:0] core_in,
  input  logic              core_valid,
  input  logic [DATA_W-1:0] core_out
);

`ifdef DES_MODE_CTR_EN
  localparam logic CTR_EN = 1'b1;
`else
  localparam logic CTR_EN = 1'b0;
`endif
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DATA_W-1:0] x_q, x_d;
  mode_e             mode_q, mode_d;
  logic [DATA_W-1:0] key_q, key_d, cin_q, cin_d, odata_q, odata_d;
  logic              cenc_q, cenc_d, oerr_q, oerr_d;
  logic [CH_W-1:0]   och_q, och_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [CH_W-1:0]   rd_ch;
  logic [DATA_W-1:0] rd_key, rd_iv, upd_iv;
  mode_e             rd_mode;
  logic              rd_enc, rd_ok, upd_en, cfg_acc, blk_bad;

  // A busy channel's context is frozen; other channels stay writable.
  assign cfg_ready   = !((state_q != IDLE) && (cfg_ch == ch_q));
  assign cfg_acc     = cfg_we && cfg_ready;
  assign in_ready    = (state_q == IDLE);
  assign core_enable = (state_q == ISSUE);
  assign out_valid   = (state_q == HOLD);
  assign core_key     = key_q;
  assign core_in      = cin_q;
  assign core_encrypt = cenc_q;
  assign out_data     = odata_q;
  assign out_err      = oerr_q;
  assign out_ch       = och_q;

  // In IDLE look at the offered channel so the block can be vetted on accept.
  assign rd_ch   = (state_q == IDLE) ? in_ch : ch_q;
  assign blk_bad = !rd_ok || (rd_mode == RSV) || ((rd_mode == CTR) && !CTR_EN);

  des_ch_ctx #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .CH_W   (CH_W)
  ) u_ctx (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (cfg_acc),
    .wr_ch_i   (cfg_ch),
    .wr_sel_i  (cfg_sel),
    .wr_data_i (cfg_wdata),
    .upd_en_i  (upd_en),
    .upd_ch_i  (ch_q),
    .upd_iv_i  (upd_iv),
    .rd_ch_i   (rd_ch),
    .key_o     (rd_key),
    .iv_o      (rd_iv),
    .mode_o    (rd_mode),
    .enc_o     (rd_enc),
    .ok_o      (rd_ok)
  );

  // Block sequencing, core operand setup, result chaining and IV update.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    x_d     = x_q;
    mode_d  = mode_q;
    key_d   = key_q;
    cin_d   = cin_q;
    cenc_d  = cenc_q;
    odata_d = odata_q;
    oerr_d  = oerr_q;
    och_d   = och_q;
    cnt_d   = cnt_q;
    upd_en  = 1'b0;
    upd_iv  = rd_iv;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ch_d   = in_ch;
          x_d    = in_data;
          mode_d = rd_mode;
          och_d  = in_ch;
          if (blk_bad) begin
            state_d = HOLD;
            oerr_d  = 1'b1;
            odata_d = '0;
          end else begin
            state_d = ISSUE;
            oerr_d  = 1'b0;
            key_d   = rd_key;
            cenc_d  = rd_enc;
            case (rd_mode)
              CBC:     cin_d = rd_enc ? (in_data ^ rd_iv) : in_data;
              CTR: begin
                cin_d  = rd_iv;
                cenc_d = 1'b1;
              end
              default: cin_d = in_data;
            endcase
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (core_valid) begin
          state_d = HOLD;
          oerr_d  = 1'b0;
          case (mode_q)
            CBC: begin
              upd_en = 1'b1;
              if (cenc_q) begin
                odata_d = core_out;
                upd_iv  = core_out;
              end else begin
                odata_d = core_out ^ rd_iv;
                upd_iv  = x_q;
              end
            end
`ifdef DES_MODE_CTR_EN
            CTR: begin
              odata_d = core_out ^ x_q;
              upd_en  = 1'b1;
              upd_iv  = rd_iv + DATA_W'(1);
            end
`endif
            default: odata_d = core_out;
          endcase
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = HOLD;
          oerr_d  = 1'b1;
          odata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any block in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      x_q     <= '0;
      mode_q  <= ECB;
      key_q   <= '0;
      cin_q   <= '0;
      cenc_q  <= 1'b1;
      odata_q <= '0;
      oerr_q  <= 1'b0;
      och_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      key_q   <= key_d;
      cin_q   <= cin_d;
      cenc_q  <= cenc_d;
      odata_q <= odata_d;
      oerr_q  <= oerr_d;
      och_q   <= och_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
